// File: rtl/gb_cpu_pkg.sv
// rtl/gb_cpu_pkg.sv - shared SM83 register index map and datapath widths
package gb_cpu_pkg;

  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 16;
  localparam int IDX_W     = 4;
  localparam int REG_COUNT = 11;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam idx_t REG_B   = 4'd0;
  localparam idx_t REG_C   = 4'd1;
  localparam idx_t REG_D   = 4'd2;
  localparam idx_t REG_E   = 4'd3;
  localparam idx_t REG_H   = 4'd4;
  localparam idx_t REG_L   = 4'd5;
  localparam idx_t REG_W   = 4'd6;
  localparam idx_t REG_Z   = 4'd7;
  localparam idx_t REG_SPH = 4'd8;
  localparam idx_t REG_SPL = 4'd9;
  localparam idx_t REG_A   = 4'd10;

  function automatic logic is_mapped(input idx_t idx);
    return idx <= REG_A;
  endfunction

  // Even indices up to SPH are the high half of a B/C..SPH/SPL pair.
  function automatic logic is_pair_hi(input idx_t idx);
    return !idx[0] && (idx <= REG_SPH);
  endfunction

endpackage

// File: rtl/gb_regfile_rdport.sv
// rtl/gb_regfile_rdport.sv - combinational read port: byte plus pair low byte
module gb_regfile_rdport
  import gb_cpu_pkg::*;
(
  input  logic [REG_COUNT-1:0][BYTE_W-1:0] regs,
  input  logic [IDX_W-1:0]                 idx,
  output logic [BYTE_W-1:0]                data,
  output logic [BYTE_W-1:0]                data_lo
);

  always_comb begin
    data    = '0;
    data_lo = '0;
    if (is_mapped(idx)) begin
      data = regs[idx];
    end
    if (is_pair_hi(idx)) begin
      data_lo = regs[idx | 4'd1];
    end
  end

endmodule

// File: rtl/gb_regfile.sv
// rtl/gb_regfile.sv - SM83 8-bit register file with pair writes and flag register
module gb_regfile
  import gb_cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              writeReg,
  input  logic [1:0]        writeEn,
  input  logic              writeFlag,
  input  logic [IDX_W-1:0]  rdReg1,
  output logic [BYTE_W-1:0] rdData1,
  output logic [BYTE_W-1:0] rdData1Lo,
  input  logic [IDX_W-1:0]  rdReg2,
  output logic [BYTE_W-1:0] rdData2,
  output logic [BYTE_W-1:0] rdData2Lo,
  input  logic [BYTE_W-1:0] flagData,
  output logic [BYTE_W-1:0] rdFlag,
  input  logic [IDX_W-1:0]  wrReg,
  input  logic [WORD_W-1:0] wrData
);

  logic [REG_COUNT-1:0][BYTE_W-1:0] regs_q, regs_d;
  logic [BYTE_W-1:0]                flag_q, flag_d;
  idx_t                             pair_hi, pair_lo;

  always_comb begin
    regs_d  = regs_q;
    flag_d  = writeFlag ? flagData : flag_q;
    // Odd pair indices fold onto their even partner, so 9 addresses SPH/SPL.
    pair_hi = {wrReg[3:1], 1'b0};
    pair_lo = {wrReg[3:1], 1'b1};
    if (writeReg) begin
      if (is_pair_hi(pair_hi)) begin
        regs_d[pair_hi] = wrData[15:8];
        regs_d[pair_lo] = wrData[7:0];
      end
    end else if (writeEn[0]) begin
      if (is_mapped(wrReg)) begin
        regs_d[wrReg] = wrData[7:0];
      end
    end else if (writeEn[1]) begin
      if (is_mapped(wrReg)) begin
        regs_d[wrReg] = wrData[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '0;
      flag_q <= '0;
    end else begin
      regs_q <= regs_d;
      flag_q <= flag_d;
    end
  end

  assign rdFlag = flag_q;

  gb_regfile_rdport u_rdport1 (
    .regs    (regs_q),
    .idx     (rdReg1),
    .data    (rdData1),
    .data_lo (rdData1Lo)
  );

  gb_regfile_rdport u_rdport2 (
    .regs    (regs_q),
    .idx     (rdReg2),
    .data    (rdData2),
    .data_lo (rdData2Lo)
  );

endmodule

// File: tb/tb_gb_regfile.sv
// tb/tb_gb_regfile.sv - directed vector bench for gb_regfile
module tb_gb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        writeReg;
  logic [1:0]  writeEn;
  logic        writeFlag;
  logic [3:0]  rdReg1, rdReg2, wrReg;
  logic [7:0]  rdData1, rdData1Lo, rdData2, rdData2Lo;
  logic [7:0]  flagData, rdFlag;
  logic [15:0] wrData;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m [0:10];
  logic [7:0] mf;

  typedef struct {
    logic [3:0] r1;
    logic [3:0] r2;
    logic [7:0] e1;
    logic [7:0] e1lo;
    logic [7:0] e2;
    logic [7:0] e2lo;
  } vec_t;

  vec_t vecs [10];

  gb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .writeReg  (writeReg),
    .writeEn   (writeEn),
    .writeFlag (writeFlag),
    .rdReg1    (rdReg1),
    .rdData1   (rdData1),
    .rdData1Lo (rdData1Lo),
    .rdReg2    (rdReg2),
    .rdData2   (rdData2),
    .rdData2Lo (rdData2Lo),
    .flagData  (flagData),
    .rdFlag    (rdFlag),
    .wrReg     (wrReg),
    .wrData    (wrData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one write cycle at the falling edge and update the reference model.
  task automatic do_write(input logic wreg, input logic [1:0] en, input logic [3:0] idx,
                          input logic [15:0] data, input logic wflag, input logic [7:0] fdata);
    logic [3:0] hi;
    @(negedge clk);
    writeReg = wreg; writeEn = en; wrReg = idx; wrData = data;
    writeFlag = wflag; flagData = fdata;
    @(posedge clk);
    #1;
    writeReg = 1'b0; writeEn = 2'b00; writeFlag = 1'b0;
    hi = {idx[3:1], 1'b0};
    if (wreg) begin
      if (hi <= 4'd8) begin
        m[hi] = data[15:8];
        m[hi + 4'd1] = data[7:0];
      end
    end else if (en[0]) begin
      if (idx <= 4'd10) m[idx] = data[7:0];
    end else if (en[1]) begin
      if (idx <= 4'd10) m[idx] = data[15:8];
    end
    if (wflag) mf = fdata;
  endtask

  task automatic rd_model(input logic [3:0] idx);
    logic [7:0] e, elo;
    e   = (idx <= 4'd10) ? m[idx] : 8'h00;
    elo = (!idx[0] && idx <= 4'd8) ? m[idx + 4'd1] : 8'h00;
    rdReg1 = idx; rdReg2 = idx;
    #1;
    chk($sformatf("model_rd1[%0d]", idx), rdData1, e);
    chk($sformatf("model_rd1lo[%0d]", idx), rdData1Lo, elo);
    chk($sformatf("model_rd2[%0d]", idx), rdData2, e);
    chk($sformatf("model_rd2lo[%0d]", idx), rdData2Lo, elo);
  endtask

  initial begin
    vecs[0] = '{4'd0,  4'd10, 8'd0,  8'd1, 8'd10, 8'd0};
    vecs[1] = '{4'd2,  4'd8,  8'd2,  8'd3, 8'd8,  8'd9};
    vecs[2] = '{4'd4,  4'd6,  8'd4,  8'd5, 8'd6,  8'd7};
    vecs[3] = '{4'd6,  4'd4,  8'd6,  8'd7, 8'd4,  8'd5};
    vecs[4] = '{4'd8,  4'd2,  8'd8,  8'd9, 8'd2,  8'd3};
    vecs[5] = '{4'd10, 4'd0,  8'd10, 8'd0, 8'd0,  8'd1};
    vecs[6] = '{4'd1,  4'd3,  8'd1,  8'd0, 8'd3,  8'd0};
    vecs[7] = '{4'd9,  4'd11, 8'd9,  8'd0, 8'd0,  8'd0};
    vecs[8] = '{4'd11, 4'd15, 8'd0,  8'd0, 8'd0,  8'd0};
    vecs[9] = '{4'd7,  4'd5,  8'd7,  8'd0, 8'd5,  8'd0};

    for (int i = 0; i < 11; i++) m[i] = 8'h00;
    mf = 8'h00;
    rst = 1'b0; writeReg = 1'b0; writeEn = 2'b00; writeFlag = 1'b0;
    rdReg1 = 4'd0; rdReg2 = 4'd0; wrReg = 4'd0; wrData = 16'h0000; flagData = 8'h00;

    // Writes attempted while held in reset must be ignored.
    @(negedge clk);
    writeEn = 2'b01; wrReg = 4'd0; wrData = 16'hFFFF; writeFlag = 1'b1; flagData = 8'hF0;
    repeat (5) @(posedge clk);
    #1;
    writeEn = 2'b00; writeFlag = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rdReg1 = 4'(i); rdReg2 = 4'(15 - i);
      #1;
      chk($sformatf("reset_rd1[%0d]", i), rdData1, 8'h00);
      chk($sformatf("reset_rd1lo[%0d]", i), rdData1Lo, 8'h00);
      chk($sformatf("reset_rd2[%0d]", 15 - i), rdData2, 8'h00);
      chk($sformatf("reset_rd2lo[%0d]", 15 - i), rdData2Lo, 8'h00);
    end
    chk("reset_flag", rdFlag, 8'h00);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) do_write(1'b0, 2'b01, 4'(i), 16'(i), 1'b0, 8'h00);

    for (int v = 0; v < 10; v++) begin
      rdReg1 = vecs[v].r1; rdReg2 = vecs[v].r2;
      #1;
      chk($sformatf("vec%0d_rd1", v), rdData1, vecs[v].e1);
      chk($sformatf("vec%0d_rd1lo", v), rdData1Lo, vecs[v].e1lo);
      chk($sformatf("vec%0d_rd2", v), rdData2, vecs[v].e2);
      chk($sformatf("vec%0d_rd2lo", v), rdData2Lo, vecs[v].e2lo);
    end

    // Pair write with writeEn also set: writeEn must be ignored.
    do_write(1'b1, 2'b11, 4'd4, 16'hBEEF, 1'b0, 8'h00);
    rdReg1 = 4'd4; #1;
    chk("pair_H", rdData1, 8'hBE);
    chk("pair_L", rdData1Lo, 8'hEF);
    do_write(1'b1, 2'b00, 4'd9, 16'h1234, 1'b0, 8'h00);
    rdReg1 = 4'd8; #1;
    chk("pair_odd_SPH", rdData1, 8'h12);
    chk("pair_odd_SPL", rdData1Lo, 8'h34);
    do_write(1'b1, 2'b00, 4'd10, 16'hFFFF, 1'b0, 8'h00);
    rdReg1 = 4'd10; rdReg2 = 4'd9; #1;
    chk("pair10_noop_A", rdData1, 8'h0A);
    chk("pair10_noop_SPL", rdData2, 8'h34);
    do_write(1'b0, 2'b10, 4'd10, 16'h5A00, 1'b0, 8'h00);
    rdReg1 = 4'd10; #1;
    chk("high_A", rdData1, 8'h5A);
    do_write(1'b0, 2'b11, 4'd0, 16'h1122, 1'b0, 8'h00);
    rdReg1 = 4'd0; #1;
    chk("en11_low_wins", rdData1, 8'h22);

    // Flag register: old value until the edge, then the new value.
    @(negedge clk);
    writeFlag = 1'b1; flagData = 8'h78;
    #1;
    chk("flag_before_edge", rdFlag, 8'h00);
    @(posedge clk); #1;
    writeFlag = 1'b0; mf = 8'h78;
    chk("flag_78", rdFlag, 8'h78);
    do_write(1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 8'h00);
    chk("flag_00", rdFlag, 8'h00);
    do_write(1'b0, 2'b01, 4'd1, 16'h0077, 1'b1, 8'hFF);
    rdReg1 = 4'd1; #1;
    chk("flag_with_reg_F", rdFlag, 8'hFF);
    chk("flag_with_reg_C", rdData1, 8'h77);

    // Unmapped write targets leave every register untouched.
    do_write(1'b0, 2'b01, 4'd12, 16'hFFFF, 1'b0, 8'h00);
    do_write(1'b0, 2'b10, 4'd15, 16'hFFFF, 1'b0, 8'h00);
    do_write(1'b1, 2'b00, 4'd11, 16'hFFFF, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) rd_model(4'(i));
    rdReg1 = 4'd3; #1;
    chk("rd3_lo_zero", rdData1Lo, 8'h00);

    // Read-during-write returns the old value until the edge.
    @(negedge clk);
    rdReg1 = 4'd2; writeEn = 2'b01; wrReg = 4'd2; wrData = 16'h00C3;
    #1;
    chk("rdw_old", rdData1, 8'h02);
    @(posedge clk); #1;
    writeEn = 2'b00; m[2] = 8'hC3;
    chk("rdw_new", rdData1, 8'hC3);

    // Async reset mid-cycle clears outputs before the next edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rd1", rdData1, 8'h00);
    chk("async_flag", rdFlag, 8'h00);
    rdReg2 = 4'd4; #1;
    chk("async_rd2", rdData2, 8'h00);
    chk("async_rd2lo", rdData2Lo, 8'h00);

    // A write colliding with reset is lost.
    writeEn = 2'b01; wrReg = 4'd6; wrData = 16'h00AA; writeFlag = 1'b1; flagData = 8'h55;
    @(posedge clk); #1;
    writeEn = 2'b00; writeFlag = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rdReg1 = 4'd6; #1;
    chk("rst_write_lost", rdData1, 8'h00);
    chk("rst_flag_lost", rdFlag, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
